regfile_mp: RTL and testbench

- Parametrised successor to the 32x64 single-write register file. Adds a second write port, write-to-read bypass, optional hardwired-zero register, optional registered read, and a per-register busy scoreboard with reserve/retire handshake.
- Sits in the datapath between decode (read/reserve) and writeback (write).

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_rd_port.sv | 68 ++++++
 rtl/regfile_mp.sv | 113 +++++++++++
 tb/tb_regfile_mp.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, index/data types and zero-register index
package regfile_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_IDX   = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one read port: write bypass, zero masking, optional output register
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int SYNC_READ = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] stored_data_i,
  input  logic              stored_busy_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] waddr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] waddr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o
);

  logic              is_zero;
  logic              hit0;
  logic              hit1;
  logic [DATA_W-1:0] sel_data;
  logic              sel_busy;
  logic [DATA_W-1:0] data_q;
  logic              busy_q;

  assign is_zero = (ZERO_REG != 0) && (raddr_i == ADDR_W'(ZERO_IDX));
  assign hit0    = (BYPASS != 0) && we0_i && (waddr0_i == raddr_i);
  assign hit1    = (BYPASS != 0) && we1_i && (waddr1_i == raddr_i);

  // A forwarded write also forwards its retire; a same-cycle reserve is not seen here.
  always_comb begin
    sel_data = stored_data_i;
    sel_busy = stored_busy_i;
    if (hit1) begin
      sel_data = wdata1_i;
      sel_busy = 1'b0;
    end else if (hit0) begin
      sel_data = wdata0_i;
      sel_busy = 1'b0;
    end
    if (is_zero) begin
      sel_data = '0;
      sel_busy = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= sel_data;
      busy_q <= sel_busy;
    end
  end

  assign rdata_o = (SYNC_READ != 0) ? data_q : sel_data;
  assign busy_o  = (SYNC_READ != 0) ? busy_q : sel_busy;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - dual-write register file with bypass and busy scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int SYNC_READ = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] readreg1,
  input  logic [ADDR_W-1:0] readreg2,
  output logic [DATA_W-1:0] readdata1,
  output logic [DATA_W-1:0] readdata2,
  output logic              busy1,
  output logic              busy2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] writereg,
  input  logic [DATA_W-1:0] writedata,
  input  logic              RegWrite2,
  input  logic [ADDR_W-1:0] writereg2,
  input  logic [DATA_W-1:0] writedata2,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reserve_reg
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic              we0_eff;
  logic              we1_eff;
  logic              res_eff;

  assign we0_eff = RegWrite  && !((ZERO_REG != 0) && (writereg    == ADDR_W'(ZERO_IDX)));
  assign we1_eff = RegWrite2 && !((ZERO_REG != 0) && (writereg2   == ADDR_W'(ZERO_IDX)));
  assign res_eff = reserve   && !((ZERO_REG != 0) && (reserve_reg == ADDR_W'(ZERO_IDX)));

  // Port 1 beats port 0 on data; reserve beats retire on busy.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      mem_d[i]  = mem_q[i];
      busy_d[i] = busy_q[i];
      if (we1_eff && (writereg2 == ADDR_W'(i))) begin
        mem_d[i]  = writedata2;
        busy_d[i] = 1'b0;
      end else if (we0_eff && (writereg == ADDR_W'(i))) begin
        mem_d[i]  = writedata;
        busy_d[i] = 1'b0;
      end
      if (res_eff && (reserve_reg == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q <= busy_d;
    end
  end

  regfile_rd_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG),
    .BYPASS(BYPASS), .SYNC_READ(SYNC_READ)
  ) u_rd1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .raddr_i      (readreg1),
    .stored_data_i(mem_q[readreg1]),
    .stored_busy_i(busy_q[readreg1]),
    .we0_i        (RegWrite),
    .waddr0_i     (writereg),
    .wdata0_i     (writedata),
    .we1_i        (RegWrite2),
    .waddr1_i     (writereg2),
    .wdata1_i     (writedata2),
    .rdata_o      (readdata1),
    .busy_o       (busy1)
  );

  regfile_rd_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG),
    .BYPASS(BYPASS), .SYNC_READ(SYNC_READ)
  ) u_rd2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .raddr_i      (readreg2),
    .stored_data_i(mem_q[readreg2]),
    .stored_busy_i(busy_q[readreg2]),
    .we0_i        (RegWrite),
    .waddr0_i     (writereg),
    .wdata0_i     (writedata),
    .we1_i        (RegWrite2),
    .waddr1_i     (writereg2),
    .wdata1_i     (writedata2),
    .rdata_o      (readdata2),
    .busy_o       (busy2)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed vector bench for regfile_mp
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  readreg1, readreg2, writereg, writereg2, reserve_reg;
  logic [63:0] writedata, writedata2;
  logic        RegWrite, RegWrite2, reserve;

  logic [63:0] rd1, rd2, nb_rd1, nb_rd2, sr_rd1, sr_rd2;
  logic        b1, b2, nb_b1, nb_b2, sr_b1, sr_b2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk(clk), .rst_n(rst_n), .readreg1(readreg1), .readreg2(readreg2),
    .readdata1(rd1), .readdata2(rd2), .busy1(b1), .busy2(b2),
    .RegWrite(RegWrite), .writereg(writereg), .writedata(writedata),
    .RegWrite2(RegWrite2), .writereg2(writereg2), .writedata2(writedata2),
    .reserve(reserve), .reserve_reg(reserve_reg)
  );

  regfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .readreg1(readreg1), .readreg2(readreg2),
    .readdata1(nb_rd1), .readdata2(nb_rd2), .busy1(nb_b1), .busy2(nb_b2),
    .RegWrite(RegWrite), .writereg(writereg), .writedata(writedata),
    .RegWrite2(RegWrite2), .writereg2(writereg2), .writedata2(writedata2),
    .reserve(reserve), .reserve_reg(reserve_reg)
  );

  regfile_mp #(.SYNC_READ(1)) u_sr (
    .clk(clk), .rst_n(rst_n), .readreg1(readreg1), .readreg2(readreg2),
    .readdata1(sr_rd1), .readdata2(sr_rd2), .busy1(sr_b1), .busy2(sr_b2),
    .RegWrite(RegWrite), .writereg(writereg), .writedata(writedata),
    .RegWrite2(RegWrite2), .writereg2(writereg2), .writedata2(writedata2),
    .reserve(reserve), .reserve_reg(reserve_reg)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic        we2;
    logic [4:0]  wr2;
    logic [63:0] wd2;
    logic        res;
    logic [4:0]  rsv;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [63:0] e_rd1;
    logic [63:0] e_rd2;
    logic        e_b1;
    logic        e_b2;
    logic [63:0] e_nb_rd1;
    logic        e_nb_b1;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mkv(
    logic we, logic [4:0] wr, logic [63:0] wd,
    logic we2, logic [4:0] wr2, logic [63:0] wd2,
    logic res, logic [4:0] rsv, logic [4:0] rr1, logic [4:0] rr2,
    logic [63:0] e_rd1, logic [63:0] e_rd2, logic e_b1, logic e_b2,
    logic [63:0] e_nb_rd1, logic e_nb_b1);
    vec_t v;
    v.we = we; v.wr = wr; v.wd = wd;
    v.we2 = we2; v.wr2 = wr2; v.wd2 = wd2;
    v.res = res; v.rsv = rsv; v.rr1 = rr1; v.rr2 = rr2;
    v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_b1 = e_b1; v.e_b2 = e_b2;
    v.e_nb_rd1 = e_nb_rd1; v.e_nb_b1 = e_nb_b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    RegWrite = 1'b0; writereg = '0; writedata = '0;
    RegWrite2 = 1'b0; writereg2 = '0; writedata2 = '0;
    reserve = 1'b0; reserve_reg = '0;
  endtask

  initial begin
    //               we wr wd                     we2 wr2 wd2                 res rsv rr1 rr2  rd1                    rd2                   b1 b2 nb_rd1                nb_b1
    vecs[0]  = mkv(0, 0,  64'h0,                 0, 0,  64'h0,               0, 0,  0,  0,  64'h0,                 64'h0,                0, 0, 64'h0,                 0);
    vecs[1]  = mkv(1, 10, 64'd12,                0, 0,  64'h0,               0, 0,  10, 10, 64'd12,                64'd12,               0, 0, 64'h0,                 0);
    vecs[2]  = mkv(0, 0,  64'h0,                 0, 0,  64'h0,               0, 0,  10, 10, 64'd12,                64'd12,               0, 0, 64'd12,                0);
    vecs[3]  = mkv(1, 7,  64'hAA,                1, 7,  64'h55,              0, 0,  7,  10, 64'h55,                64'd12,               0, 0, 64'h0,                 0);
    vecs[4]  = mkv(0, 0,  64'h0,                 0, 0,  64'h0,               0, 0,  7,  7,  64'h55,                64'h55,               0, 0, 64'h55,                0);
    vecs[5]  = mkv(1, 0,  64'hFFFF,              0, 0,  64'h0,               1, 0,  0,  0,  64'h0,                 64'h0,                0, 0, 64'h0,                 0);
    vecs[6]  = mkv(0, 0,  64'h0,                 0, 0,  64'h0,               0, 0,  0,  0,  64'h0,                 64'h0,                0, 0, 64'h0,                 0);
    vecs[7]  = mkv(0, 0,  64'h0,                 0, 0,  64'h0,               1, 12, 12, 12, 64'h0,                 64'h0,                0, 0, 64'h0,                 0);
    vecs[8]  = mkv(0, 0,  64'h0,                 0, 0,  64'h0,               0, 0,  12, 10, 64'h0,                 64'd12,               1, 0, 64'h0,                 1);
    vecs[9]  = mkv(1, 12, 64'h99,                0, 0,  64'h0,               1, 12, 12, 12, 64'h99,                64'h99,               0, 0, 64'h0,                 1);
    vecs[10] = mkv(0, 0,  64'h0,                 0, 0,  64'h0,               0, 0,  12, 12, 64'h99,                64'h99,               1, 1, 64'h99,                1);
    vecs[11] = mkv(0, 0,  64'h0,                 1, 12, 64'h77,              0, 0,  12, 3,  64'h77,                64'h0,                0, 0, 64'h99,                1);
    vecs[12] = mkv(0, 0,  64'h0,                 0, 0,  64'h0,               0, 0,  12, 12, 64'h77,                64'h77,               0, 0, 64'h77,                0);
    vecs[13] = mkv(1, 31, 64'hDEADBEEFCAFEF00D,  1, 30, 64'h0123456789ABCDEF, 0, 0, 31, 30, 64'hDEADBEEFCAFEF00D,  64'h0123456789ABCDEF, 0, 0, 64'h0,                 0);
    vecs[14] = mkv(0, 0,  64'h0,                 0, 0,  64'h0,               0, 0,  31, 30, 64'hDEADBEEFCAFEF00D,  64'h0123456789ABCDEF, 0, 0, 64'hDEADBEEFCAFEF00D,  0);
    vecs[15] = mkv(1, 12, 64'h1,                 0, 0,  64'h0,               0, 0,  12, 31, 64'h1,                 64'hDEADBEEFCAFEF00D,  0, 0, 64'h77,                0);

    rst_n = 1'b0;
    idle();
    readreg1 = 5'd7;
    readreg2 = 5'd12;
    #1;
    chk("reset rd1", rd1, 64'h0);
    chk("reset b2", {63'h0, b2}, 64'h0);
    chk("reset sr_rd1", sr_rd1, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      RegWrite = vecs[i].we; writereg = vecs[i].wr; writedata = vecs[i].wd;
      RegWrite2 = vecs[i].we2; writereg2 = vecs[i].wr2; writedata2 = vecs[i].wd2;
      reserve = vecs[i].res; reserve_reg = vecs[i].rsv;
      readreg1 = vecs[i].rr1; readreg2 = vecs[i].rr2;
      #1;
      chk($sformatf("v%0d rd1", i), rd1, vecs[i].e_rd1);
      chk($sformatf("v%0d rd2", i), rd2, vecs[i].e_rd2);
      chk($sformatf("v%0d b1", i), {63'h0, b1}, {63'h0, vecs[i].e_b1});
      chk($sformatf("v%0d b2", i), {63'h0, b2}, {63'h0, vecs[i].e_b2});
      chk($sformatf("v%0d nb_rd1", i), nb_rd1, vecs[i].e_nb_rd1);
      chk($sformatf("v%0d nb_b1", i), {63'h0, nb_b1}, {63'h0, vecs[i].e_nb_b1});
    end

    // Registered read: one-edge latency, bypass captured at the edge
    @(negedge clk);
    idle();
    readreg1 = 5'd3; readreg2 = 5'd3;
    @(posedge clk); #1;
    chk("sr idle rd1", sr_rd1, 64'h0);
    @(negedge clk);
    RegWrite = 1'b1; writereg = 5'd3; writedata = 64'h1234;
    #1;
    chk("sr before edge rd1", sr_rd1, 64'h0);
    @(posedge clk); #1;
    chk("sr after edge rd1", sr_rd1, 64'h1234);
    chk("sr after edge b1", {63'h0, sr_b1}, 64'h0);

    @(negedge clk);
    idle();
    reserve = 1'b1; reserve_reg = 5'd12;
    readreg1 = 5'd3; readreg2 = 5'd12;
    @(negedge clk);
    reserve = 1'b0;
    #1;
    chk("busy12 rd1", rd1, 64'h1234);
    chk("busy12 rd2", rd2, 64'h1);
    chk("busy12 b2", {63'h0, b2}, 64'h1);
    @(posedge clk); #1;
    chk("sr busy12 b2", {63'h0, sr_b2}, 64'h1);
    chk("sr busy12 rd2", sr_rd2, 64'h1);

    // Asynchronous reset mid-cycle clears everything without an edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst rd1", rd1, 64'h0);
    chk("async rst rd2", rd2, 64'h0);
    chk("async rst b2", {63'h0, b2}, 64'h0);
    chk("async rst sr_rd1", sr_rd1, 64'h0);
    chk("async rst sr_b2", {63'h0, sr_b2}, 64'h0);
    chk("async rst nb_rd1", nb_rd1, 64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    readreg1 = 5'd7; readreg2 = 5'd31;
    #1;
    chk("post rst rd1", rd1, 64'h0);
    chk("post rst rd2", rd2, 64'h0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
